// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, addresses the combinational instruction ROM and loads the IF/ID register.
// Redirects squash the wrong-path fetch; an invalid PC latches a sticky fault until reset.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_RUN   | normal fetch: redirect > stall > sequential
//  ST_FAULT | PC frozen, IF/ID held at NOP/invalid, exits only via reset
module instruction_fetch_stage #(
   parameter int          DATA_WIDTH = 32,
   parameter int          ADDR_WIDTH = 8,
   parameter logic [31:0] PC_RESET   = 32'h0040_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall_i,
   input  logic [1:0]            pc_src_i,
   input  logic [31:0]           branch_target_i,
   input  logic [25:0]           jump_index_i,
   input  logic [31:0]           jr_target_i,
   output logic [ADDR_WIDTH-1:0] rom_addr_o,
   input  logic [DATA_WIDTH-1:0] rom_data_i,
   output logic [31:0]           pc_o,
   output logic [DATA_WIDTH-1:0] if_id_instr_o,
   output logic [31:0]           if_id_pc_plus4_o,
   output logic                  if_id_valid_o,
   output logic                  fetch_fault_o
);

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_FAULT = 1'b1;

   localparam logic [1:0] SRC_SEQ    = 2'b00;
   localparam logic [1:0] SRC_BRANCH = 2'b01;
   localparam logic [1:0] SRC_JUMP   = 2'b10;

   logic [0:0]            state_q, state_d;
   logic [31:0]           pc_q, pc_d;
   logic [DATA_WIDTH-1:0] instr_q, instr_d;
   logic [31:0]           pc4_q, pc4_d;
   logic                  valid_q, valid_d;
   logic                  fault_q, fault_d;

   logic [31:0] pc_off;
   logic [31:0] pc_plus4;
   logic [31:0] target;
   logic        pc_bad;

   assign pc_off   = pc_q - PC_RESET;
   assign pc_plus4 = pc_q + 32'd4;

   // Below-base PCs wrap to a huge offset, but are also rejected explicitly.
   assign pc_bad = (pc_q[1:0] != 2'b00) || (pc_q < PC_RESET)
                   || (pc_off[31:ADDR_WIDTH+2] != '0);

   assign rom_addr_o = pc_off[ADDR_WIDTH+1:2];

   always_comb begin
      target = jr_target_i;
      case (pc_src_i)
         SRC_BRANCH: target = branch_target_i;
         SRC_JUMP:   target = {pc4_q[31:28], jump_index_i, 2'b00};
         default:    target = jr_target_i;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      fault_d = fault_q;
      case (state_q)
         ST_RUN: begin
            if (pc_bad) begin
               state_d = ST_FAULT;
               fault_d = 1'b1;
               instr_d = '0;
               pc4_d   = '0;
               valid_d = 1'b0;
            end else if (pc_src_i != SRC_SEQ) begin
               pc_d    = target;
               instr_d = '0;
               pc4_d   = '0;
               valid_d = 1'b0;
            end else if (!stall_i) begin
               pc_d    = pc_plus4;
               instr_d = rom_data_i;
               pc4_d   = pc_plus4;
               valid_d = 1'b1;
            end
         end
         default: begin
            instr_d = '0;
            pc4_d   = '0;
            valid_d = 1'b0;
            fault_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_RUN;
         pc_q    <= PC_RESET;
         instr_q <= '0;
         pc4_q   <= '0;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
         fault_q <= fault_d;
      end
   end

   assign pc_o             = pc_q;
   assign if_id_instr_o    = instr_q;
   assign if_id_pc_plus4_o = pc4_q;
   assign if_id_valid_o    = valid_q;
   assign fetch_fault_o    = fault_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed walk through fetch, stall, redirects and faults,
// then random traffic, all compared against a cycle-level reference model of the IF stage.
module tb_instruction_fetch_stage;

   localparam logic [31:0] BASE   = 32'h0040_0000;
   localparam int          AW     = 8;
   localparam int          NWORDS = 256;

   logic          clk = 1'b0;
   logic          reset;
   logic          stall_i;
   logic [1:0]    pc_src_i;
   logic [31:0]   branch_target_i;
   logic [25:0]   jump_index_i;
   logic [31:0]   jr_target_i;
   logic [AW-1:0] rom_addr_o;
   logic [31:0]   rom_data_i;
   logic [31:0]   pc_o;
   logic [31:0]   if_id_instr_o;
   logic [31:0]   if_id_pc_plus4_o;
   logic          if_id_valid_o;
   logic          fetch_fault_o;

   logic [31:0] rom [NWORDS];

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid, m_fault;

   always #5 clk = ~clk;

   assign rom_data_i = rom[rom_addr_o];

   instruction_fetch_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .PC_RESET(BASE)) dut (
      .clk              (clk),
      .reset            (reset),
      .stall_i          (stall_i),
      .pc_src_i         (pc_src_i),
      .branch_target_i  (branch_target_i),
      .jump_index_i     (jump_index_i),
      .jr_target_i      (jr_target_i),
      .rom_addr_o       (rom_addr_o),
      .rom_data_i       (rom_data_i),
      .pc_o             (pc_o),
      .if_id_instr_o    (if_id_instr_o),
      .if_id_pc_plus4_o (if_id_pc_plus4_o),
      .if_id_valid_o    (if_id_valid_o),
      .fetch_fault_o    (fetch_fault_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit pc_invalid(input logic [31:0] pc);
      return (pc % 4 != 0) || (pc < BASE) || ((pc - BASE) >= 4 * NWORDS);
   endfunction

   // One clock: drive inputs, advance the model by the IF-stage rules, compare everything.
   task automatic step(input bit rst, input bit st, input logic [1:0] src,
                       input logic [31:0] bt, input logic [25:0] ji, input logic [31:0] jt);
      logic [31:0] tgt;
      reset = rst; stall_i = st; pc_src_i = src;
      branch_target_i = bt; jump_index_i = ji; jr_target_i = jt;
      if (rst && !m_fault && !pc_invalid(m_pc))
         chk("rom_addr", {24'b0, rom_addr_o}, ((m_pc - BASE) / 4) % NWORDS);
      tgt = (src == 2'd1) ? bt : (src == 2'd2) ? {m_pc4[31:28], ji, 2'b00} : jt;
      if (!rst) begin
         m_pc = BASE; m_instr = 0; m_pc4 = 0; m_valid = 0; m_fault = 0;
      end else if (m_fault) begin
         // frozen
      end else if (pc_invalid(m_pc)) begin
         m_fault = 1; m_instr = 0; m_pc4 = 0; m_valid = 0;
      end else if (src != 2'd0) begin
         m_pc = tgt; m_instr = 0; m_pc4 = 0; m_valid = 0;
      end else if (!st) begin
         m_instr = rom[(m_pc - BASE) / 4];
         m_pc    = m_pc + 4;
         m_pc4   = m_pc;
         m_valid = 1;
      end
      @(posedge clk);
      #1;
      chk("pc", pc_o, m_pc);
      chk("instr", if_id_instr_o, m_instr);
      chk("pc_plus4", if_id_pc_plus4_o, m_pc4);
      chk("valid", {31'b0, if_id_valid_o}, {31'b0, m_valid});
      chk("fault", {31'b0, fetch_fault_o}, {31'b0, m_fault});
   endtask

   task automatic seq();
      step(1, 0, 2'd0, 0, 0, 0);
   endtask

   initial begin
      logic [31:0] t;
      bit          r, s;
      logic [1:0]  src;
      for (int i = 0; i < NWORDS; i++) rom[i] = $urandom;
      rom[0] = 32'h2008_0005; rom[1] = 32'h2009_0003;
      rom[2] = 32'h0109_5020; rom[3] = 32'hAC0A_0000;
      m_pc = BASE; m_instr = 0; m_pc4 = 0; m_valid = 0; m_fault = 0;
      reset = 0; stall_i = 0; pc_src_i = 0;
      branch_target_i = 0; jump_index_i = 0; jr_target_i = 0;

      step(0, 0, 2'd0, 0, 0, 0);
      step(0, 0, 2'd0, 0, 0, 0);
      chk("reset_pc_const", pc_o, 32'h0040_0000);
      seq();
      chk("first_instr_const", if_id_instr_o, 32'h2008_0005);
      chk("first_pc4_const", if_id_pc_plus4_o, 32'h0040_0004);
      seq();                                   // pc = 08
      step(1, 1, 2'd0, 0, 0, 0);               // stall holds
      chk("stall_pc_const", pc_o, 32'h0040_0008);
      seq();                                   // pc = 0C
      chk("resume_pc_const", pc_o, 32'h0040_000C);
      seq();                                   // pc = 10, pc4 = 10
      step(1, 0, 2'd2, 0, 26'h010_0004, 0);    // jump
      chk("jump_pc_const", pc_o, 32'h0040_0010);
      seq();
      step(1, 0, 2'd3, 0, 0, 32'h0040_003C);   // jr
      chk("jr_pc_const", pc_o, 32'h0040_003C);
      seq();
      step(1, 0, 2'd1, 32'h0040_0020, 0, 0);   // branch
      chk("branch_pc_const", pc_o, 32'h0040_0020);
      seq();
      chk("word8_const", if_id_instr_o, rom[8]);
      step(1, 1, 2'd1, 32'h0040_0080, 0, 0);   // stall + branch -> branch wins
      step(0, 1, 2'd0, 0, 0, 0);               // reset + stall -> reset wins
      seq(); seq();
      step(1, 0, 2'd3, 0, 0, 32'h0040_0002);   // misaligned jr
      step(1, 0, 2'd0, 0, 0, 0);
      chk("fault_const", {31'b0, fetch_fault_o}, 32'd1);
      for (int i = 0; i < 5; i++)
         step(1, i[0], 2'(i), 32'h0040_0010, 26'h3, 32'h0040_0000);
      step(0, 0, 2'd0, 0, 0, 0);
      step(1, 0, 2'd3, 0, 0, BASE + 4 * (NWORDS - 1));
      seq();                                   // last word fetched, pc = 0x00400400
      seq();                                   // fault, no wrap
      chk("runoff_pc_const", pc_o, 32'h0040_0400);
      seq();
      step(0, 0, 2'd0, 0, 0, 0);

      for (int i = 0; i < 400; i++) begin
         r   = m_fault ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 39) != 0);
         s   = ($urandom_range(0, 3) == 0);
         src = ($urandom_range(0, 9) < 7) ? 2'd0 : 2'($urandom_range(1, 3));
         t   = BASE + 4 * $urandom_range(0, NWORDS - 1);
         case ($urandom_range(0, 19))
            0: t = t + 2;
            1: t = BASE - 4;
            2: t = BASE + 4 * NWORDS;
            default: ;
         endcase
         step(r, s, src, t, 26'(t >> 2), t);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
